// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer.
package modexp_pkg;

  localparam int MODEXP_N       = 512;
  localparam int MODEXP_E_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    SQR_GO,
    SQR_WAIT,
    MUL_GO,
    MUL_WAIT,
    CONV_GO,
    CONV_WAIT,
    FIN
  } state_t;

  // Operand sources for the multiplier a/b ports.
  typedef enum logic [1:0] {
    OPSEL_ZERO,
    OPSEL_ACC,
    OPSEL_BASE,
    OPSEL_ONE
  } op_sel_t;

  function automatic logic is_go_state(input state_t s);
    return (s == SQR_GO) || (s == MUL_GO) || (s == CONV_GO);
  endfunction

endpackage

// File: rtl/exp_bit_scanner.sv
// Walks the exponent MSB-first: holds the current bit and flags the last one (index 0).
module exp_bit_scanner
  import modexp_pkg::*;
#(
  parameter int E_WIDTH = MODEXP_E_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [E_WIDTH-1:0] e_i,
  input  logic               step_i,
  output logic               bit_o,
  output logic               last_o
);

  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(E_WIDTH - 1);

  logic [E_WIDTH-1:0] e_q, e_d;
  logic [IW-1:0]      idx_q, idx_d;

  // The exponent shifts left so the bit under consideration is always the MSB.
  always_comb begin
    e_d   = e_q;
    idx_d = idx_q;
    if (load_i) begin
      e_d   = e_i;
      idx_d = TOP_IDX;
    end else if (step_i && (idx_q != '0)) begin
      e_d   = e_q << 1;
      idx_d = idx_q - IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q   <= '0;
      idx_q <= '0;
    end else begin
      e_q   <= e_d;
      idx_q <= idx_d;
    end
  end

  assign bit_o  = e_q[E_WIDTH-1];
  assign last_o = (idx_q == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer feeding an external Montgomery multiplier.
// Define MODEXP_FINAL_CONVERT_EN to append MontMul(A,1) so result leaves the Montgomery domain.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int N       = MODEXP_N,
  parameter int E_WIDTH = MODEXP_E_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       in_x,
  input  logic [N-1:0]       in_r,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [N-1:0]       in_m,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       result,
  output logic               mm_start,
  output logic [N+1:0]       mm_a,
  output logic [N+1:0]       mm_b,
  output logic [N+1:0]       mm_m,
  input  logic [N-1:0]       mm_result,
  input  logic               mm_done
);

`ifdef MODEXP_FINAL_CONVERT_EN
  localparam state_t AFTER_LAST_BIT = CONV_GO;
`else
  localparam state_t AFTER_LAST_BIT = FIN;
`endif

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] m_q, m_d;
  logic [N-1:0] result_q, result_d;
  logic         done_q, done_d;
  logic         scan_load, scan_step;
  logic         cur_bit, last_bit;
  op_sel_t      sel_a, sel_b;

  function automatic logic [N+1:0] operand(input op_sel_t sel,
                                           input logic [N-1:0] acc,
                                           input logic [N-1:0] base);
    logic [N+1:0] v;
    case (sel)
      OPSEL_ACC:  v = {2'b00, acc};
      OPSEL_BASE: v = {2'b00, base};
      OPSEL_ONE:  v = {{(N+1){1'b0}}, 1'b1};
      default:    v = '0;
    endcase
    return v;
  endfunction

  exp_bit_scanner #(
    .E_WIDTH(E_WIDTH)
  ) u_scanner (
    .clk    (clk),
    .reset  (reset),
    .load_i (scan_load),
    .e_i    (in_e),
    .step_i (scan_step),
    .bit_o  (cur_bit),
    .last_o (last_bit)
  );

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    x_d       = x_q;
    m_d       = m_q;
    result_d  = result_q;
    done_d    = 1'b0;
    scan_load = 1'b0;
    scan_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d       = in_x;
          m_d       = in_m;
          a_d       = in_r;
          scan_load = 1'b1;
          state_d   = SQR_GO;
        end
      end
      SQR_GO: state_d = SQR_WAIT;
      SQR_WAIT: begin
        if (mm_done) begin
          a_d = mm_result;
          if (cur_bit) begin
            state_d = MUL_GO;
          end else if (last_bit) begin
            state_d = AFTER_LAST_BIT;
          end else begin
            scan_step = 1'b1;
            state_d   = SQR_GO;
          end
        end
      end
      MUL_GO: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mm_done) begin
          a_d = mm_result;
          if (last_bit) begin
            state_d = AFTER_LAST_BIT;
          end else begin
            scan_step = 1'b1;
            state_d   = SQR_GO;
          end
        end
      end
`ifdef MODEXP_FINAL_CONVERT_EN
      CONV_GO: state_d = CONV_WAIT;
      CONV_WAIT: begin
        if (mm_done) begin
          a_d     = mm_result;
          state_d = FIN;
        end
      end
`endif
      FIN: begin
        result_d = a_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands derive from state and latched registers only, so they hold from GO through mm_done.
  always_comb begin
    sel_a = OPSEL_ZERO;
    sel_b = OPSEL_ZERO;
    case (state_q)
      SQR_GO, SQR_WAIT: begin
        sel_a = OPSEL_ACC;
        sel_b = OPSEL_ACC;
      end
      MUL_GO, MUL_WAIT: begin
        sel_a = OPSEL_ACC;
        sel_b = OPSEL_BASE;
      end
      CONV_GO, CONV_WAIT: begin
        sel_a = OPSEL_ACC;
        sel_b = OPSEL_ONE;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      x_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      x_q      <= x_d;
      m_q      <= m_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign mm_a     = operand(sel_a, a_q, x_q);
  assign mm_b     = operand(sel_b, a_q, x_q);
  assign mm_m     = {2'b00, m_q};
  assign mm_start = is_go_state(state_q);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl with a behavioural Montgomery multiplier (latency L) and a result scoreboard.
module tb_modexp_ctrl;

  localparam int N  = 512;
  localparam int EW = 4;
  localparam int L  = 5;
  localparam logic [127:0] MOD   = 128'd243440200464345627;
  localparam logic [127:0] XBASE = 128'd422335678912344321;
  localparam logic [N+1:0] ONE_EXT = {{(N+1){1'b0}}, 1'b1};
`ifdef MODEXP_FINAL_CONVERT_EN
  localparam int CONV_OPS = 1;
`else
  localparam int CONV_OPS = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [N-1:0]  in_x = '0, in_r = '0, in_m = '0;
  logic [EW-1:0] in_e = '0;
  logic          busy, done, mm_start;
  logic [N-1:0]  result;
  logic [N+1:0]  mm_a, mm_b, mm_m;
  logic [N-1:0]  mm_result;
  logic          mm_done;

  logic          model_done = 1'b0;
  logic [N-1:0]  model_res = '0;
  logic          inject = 1'b0;
  logic [N-1:0]  inj_res = '0;
  assign mm_done   = model_done | inject;
  assign mm_result = inject ? inj_res : model_res;

  modexp_ctrl #(.N(N), .E_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_m(in_m),
    .busy(busy), .done(done), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  function automatic logic [N-1:0] mont(input logic [N+1:0] a, input logic [N+1:0] b,
                                        input logic [N+1:0] m);
    logic [N+2:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {1'b0, b};
      if (t[0]) t = t + {1'b0, m};
      t = t >> 1;
    end
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[N-1:0];
  endfunction

  function automatic logic [127:0] mulmod(input logic [127:0] a, input logic [127:0] b);
    return (a * b) % MOD;
  endfunction

  function automatic logic [127:0] powmod(input logic [127:0] b, input logic [3:0] e);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 3; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, b);
    end
    return r;
  endfunction

  function automatic int lat_of(input int pop);
    return 2 + (EW + pop + CONV_OPS) * (L + 1);
  endfunction

  // Behavioural multiplier plus operand-stability and pulse-kind logging.
  logic [N+1:0] lat_a = '0, lat_b = '0, lat_m = '0;
  logic [N-1:0] cur_base = '0, cur_m = '0;
  int   mm_cnt = 0, stab_err = 0, mmm_err = 0, cyc = 0;
  byte  pulse_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_cnt     <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if ((mm_cnt > 0 || model_done) && (mm_a !== lat_a || mm_b !== lat_b || mm_m !== lat_m))
        stab_err <= stab_err + 1;
      if (mm_start) begin
        lat_a  <= mm_a;
        lat_b  <= mm_b;
        lat_m  <= mm_m;
        mm_cnt <= L - 1;
        if (mm_m !== {2'b00, cur_m}) mmm_err <= mmm_err + 1;
        if (mm_b === mm_a)                 pulse_q.push_back("S");
        else if (mm_b === ONE_EXT)         pulse_q.push_back("C");
        else if (mm_b === {2'b00, cur_base}) pulse_q.push_back("M");
        else                               pulse_q.push_back("?");
      end else if (mm_cnt > 0) begin
        mm_cnt <= mm_cnt - 1;
        if (mm_cnt == 1) begin
          model_done <= 1'b1;
          model_res  <= mont(lat_a, lat_b, lat_m);
        end
      end
    end
  end

  logic [N-1:0] exp_q[$];
  int total = 0, bad = 0;
  int p0 = 0, s0 = 0, m0 = 0, s_cyc = 0;
  logic [N-1:0] m_n, r_n, xm_n, exp0_n, exp11_n;
  string seq0, seq11;

  task automatic launch(input logic [N-1:0] x, input logic [N-1:0] r, input logic [3:0] e,
                        input logic [N-1:0] expv);
    exp_q.push_back(expv);
    cur_base = x;
    cur_m    = m_n;
    p0 = pulse_q.size();
    s0 = stab_err;
    m0 = mmm_err;
    in_x = x; in_r = r; in_m = m_n; in_e = e;
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
  endtask

  task automatic finish(input string name, input string seq, input int lat_exp);
    int n, np;
    bit ok;
    logic [N-1:0] expv;
    n = 0;
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s done_timeout: no done after %0d cycles", name, n);
      exp_q.delete();
      return;
    end
    expv = exp_q.pop_front();
    total++;
    if (result !== expv) begin bad++; $display("FAIL %s result: got %0h want %0h", name, result, expv); end
    total++;
    if (cyc - s_cyc != lat_exp) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc - s_cyc, lat_exp);
    end
    np = pulse_q.size() - p0;
    total++;
    if (np != seq.len()) begin bad++; $display("FAIL %s pulse_count: got %0d want %0d", name, np, seq.len()); end
    ok = (np == seq.len());
    for (int k = 0; k < np && k < seq.len(); k++) if (pulse_q[p0+k] != seq[k]) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL %s pulse_order: got other sequence want %s", name, seq); end
    total++;
    if (stab_err != s0 || mmm_err != m0) begin
      bad++; $display("FAIL %s operands: got %0d unstable / %0d bad mm_m want 0/0", name, stab_err - s0, mmm_err - m0);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s done_pulse: got done=%b busy=%b want 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (result !== '0)     begin bad++; $display("FAIL rst_result: got %0h want 0", result); end
    total++; if (mm_start !== 1'b0) begin bad++; $display("FAIL rst_mm_start: got %b want 0", mm_start); end
    total++; if (mm_a !== '0 || mm_b !== '0 || mm_m !== '0) begin
      bad++; $display("FAIL rst_operands: got a=%0h b=%0h m=%0h want 0", mm_a, mm_b, mm_m);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_e_zero();
    launch(xm_n, r_n, 4'b0000, exp0_n);
    finish("e0000", seq0, lat_of(0));
  endtask

  task automatic test_e_1011();
    launch(xm_n, r_n, 4'b1011, exp11_n);
    finish("e1011", seq11, lat_of(3));
  endtask

  task automatic test_start_while_busy();
    launch(xm_n, r_n, 4'b1011, exp11_n);
    while (cyc < s_cyc + 3) @(negedge clk);
    start = 1'b1; in_e = 4'b0000; in_x = ~xm_n; in_r = '0; in_m = m_n + 2;
    @(negedge clk);
    start = 1'b0;
    finish("restart_ignored", seq11, lat_of(3));
    repeat (5) @(negedge clk);
    total++;
    if (result !== exp11_n) begin bad++; $display("FAIL result_hold: got %0h want %0h", result, exp11_n); end
  endtask

  task automatic test_reset_mid_mul();
    int n;
    bit saw_done;
    launch(xm_n, r_n, 4'b1011, exp11_n);
    n = 0;
    while (pulse_q.size() < p0 + 2 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (pulse_q.size() < p0 + 2) begin bad++; $display("FAIL mid_mul_timeout: got %0d pulses want 2", pulse_q.size() - p0); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0 || result !== '0 ||
        mm_a !== '0 || mm_b !== '0 || mm_m !== '0) begin
      bad++; $display("FAIL async_reset: got busy=%b done=%b mm_start=%b a=%0h want all 0", busy, done, mm_start, mm_a);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    saw_done = 1'b0;
    repeat (60) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1; end
    total++;
    if (saw_done) begin bad++; $display("FAIL no_done_after_reset: got activity want idle"); end
    launch(xm_n, r_n, 4'b1011, exp11_n);
    finish("after_reset", seq11, lat_of(3));
  endtask

  task automatic test_mm_done_inject();
    inj_res = {N{1'b1}};
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== exp11_n) begin
      bad++; $display("FAIL idle_inject: got busy=%b done=%b result=%0h want 0/0/%0h", busy, done, result, exp11_n);
    end
    launch(xm_n, r_n, 4'b1011, exp11_n);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    finish("go_inject", seq11, lat_of(3));
  endtask

  task automatic test_start_at_fin();
    logic [N-1:0] expv;
    launch(xm_n, r_n, 4'b0000, exp0_n);
    while (cyc < s_cyc + lat_of(0) - 1) @(negedge clk);
    start = 1'b1; in_e = 4'b1011;
    @(negedge clk);
    start = 1'b0;
    expv = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || result !== expv) begin
      bad++; $display("FAIL fin_done: got done=%b result=%0h want 1/%0h", done, result, expv);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL fin_start_ignored: got busy=%b want 0", busy); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL fin_stays_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    logic [127:0] r128, x128;
    r128 = 128'd1;
    repeat (N) r128 = (r128 << 1) % MOD;
    x128 = XBASE % MOD;
    m_n  = N'(MOD);
    r_n  = N'(r128);
    xm_n = N'(mulmod(x128, r128));
    if (CONV_OPS != 0) begin
      exp0_n  = N'(128'd1);
      exp11_n = N'(powmod(x128, 4'b1011));
      seq0    = "SSSSC";
      seq11   = "SMSSMSMC";
    end else begin
      exp0_n  = r_n;
      exp11_n = N'(mulmod(powmod(x128, 4'b1011), r128));
      seq0    = "SSSS";
      seq11   = "SMSSMSM";
    end

    test_reset();
    test_e_zero();
    test_e_1011();
    test_start_while_busy();
    test_reset_mid_mul();
    test_mm_done_inject();
    test_start_at_fin();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencer for left-to-right square-and-multiply modular exponentiation. It sits directly upstream of the `montgomery` multiplier: it issues every operand pair and `start` pulse, and consumes each `result`/`done`. The block computes the Montgomery-domain power X̃^E mod M from a Montgomery-form base, the Montgomery one (R mod M), an exponent and a modulus.

## Interface
- `N`, 512: operand width; the multiplier ports are N+2 bits wide and its result is N bits.
- `E_WIDTH`, 16: exponent width in bits, ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `in_x` in N: base in Montgomery form (x·R mod M).
- `in_r` in N: R mod M, the Montgomery one.
- `in_e` in E_WIDTH: exponent.
- `in_m` in N: odd modulus.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when `result` is valid.
- `result` out N: final accumulator; held until the next accepted `start`.
- `mm_start` out 1: one-cycle start pulse to the multiplier.
- `mm_a`, `mm_b`, `mm_m` out N+2: multiplier operands, zero-extended by 2 bits.
- `mm_result` in N: multiplier product.
- `mm_done` in 1: multiplier completion pulse.

## Operation
- On `start` in IDLE, latch in_x, in_e, in_m; A ← in_r; bit index i ← E_WIDTH-1.
- States and transitions:
  - IDLE →(start)→ SQR_GO.
  - SQR_GO: mm_a=mm_b=A, `mm_start`=1 for one cycle → SQR_WAIT.
  - SQR_WAIT: on mm_done, A ← mm_result. If e[i]=1 → MUL_GO. Otherwise, if i=0 → FIN, else i−1 → SQR_GO.
  - MUL_GO: mm_a=A, mm_b=X, pulse `mm_start` → MUL_WAIT.
  - MUL_WAIT: on mm_done, A ← mm_result. If i=0 → FIN, else i−1 → SQR_GO.
  - FIN: result ← A, `done`=1 → IDLE.
- `mm_m` is always the latched M. Operands stay stable from the `mm_start` cycle through the `mm_done` cycle.
- Multiplier count: E_WIDTH squarings plus popcount(e) multiplies.
- e=0 gives result = in_r.
- Boundary rules:
  - `start` while busy: ignored; latched inputs are unchanged.
  - `mm_done` outside a WAIT state: ignored.
  - `reset` asserted at any time: immediately IDLE, no partial `done`. The multiplier's own reset must be driven in step by the top level.
  - `start` in the same cycle as FIN: not accepted, because the FSM is not yet in IDLE.

## Timing
- Reset values: busy=0, done=0, result=0, mm_start=0, mm_a/mm_b/mm_m=0, FSM=IDLE.
- Let L = cycles from the `mm_start` edge to the `mm_done` edge. Each operation costs L+1 cycles: GO plus the WAIT cycles.
- Total from the `start` edge to the `done` edge: 1 + (E_WIDTH + popcount(e))·(L+1) + 1.
- `result` updates on the same edge on which `done` rises.

## Configuration
- `MODEXP_FINAL_CONVERT_EN` defined: FIN is preceded by CONV_GO/CONV_WAIT, which runs MontMul(A, 1), i.e. mm_b = 1 zero-extended. `result` is then the plain value x^e mod M. Latency grows by L+1.
- Macro undefined: `result` stays in the Montgomery domain, and the CONV states do not exist.

## Structure
- Package `modexp_pkg` holds:
  - the state enum: IDLE, SQR_GO, SQR_WAIT, MUL_GO, MUL_WAIT, CONV_GO, CONV_WAIT, FIN;
  - the default N and E_WIDTH constants;
  - operand-select constants.
- One natural sub-module, `exp_bit_scanner`: loads in_e, presents the current bit, and steps i on command. It flags the last bit when i=0.
- The operand muxes and the accumulator stay in `modexp_ctrl`.

## Test plan
All cases use N=512, E_WIDTH=4, M=243440200464345627, and a bench-side behavioural multiplier model with L=5.
- e=4'b0000 → exactly 4 mm_start pulses, all squarings; result=in_r; done at cycle 1+4·6+1=26 after start.
- e=4'b1011, x=422335678912344321 in Montgomery form → 7 mm_start pulses in the order S,M,S,S,M,S,M. result equals the model's x^11·R mod M.
- `start` re-pulsed at cycle 3 of a run → ignored; latched E unchanged; result identical to the previous case.
- `reset` asserted mid MUL_WAIT → outputs return to reset values within the same cycle; no done. A fresh start then completes normally.
- `mm_done` injected while in IDLE or GO → no state or A change.
- With `MODEXP_FINAL_CONVERT_EN` and e=4'b1011 → 8 pulses; result = x^11 mod M in plain form.
